// File: rtl/sha256_id_buf_v2_if.sv
// Handshake bundle between the SHA-256 message-ID source, the ID FIFO and the hash output stage.
// The FIFO takes the slave view; the producer/consumer side takes the master view.
interface sha256_id_buf_v2_if #(
   parameter int ID_W = 6
) ();
   logic [ID_W-1:0] id_in;
   logic            id_in_last;
   logic            id_in_valid;
   logic            id_in_ready;
   logic [ID_W-1:0] id_out;
   logic            id_out_last;
   logic            id_out_valid;
   logic            id_out_ready;

   modport master (
      output id_in, id_in_last, id_in_valid, id_out_ready,
      input  id_in_ready, id_out, id_out_last, id_out_valid
   );

   modport slave (
      input  id_in, id_in_last, id_in_valid, id_out_ready,
      output id_in_ready, id_out, id_out_last, id_out_valid
   );
endinterface

// File: rtl/sha256_id_buf_v2.sv
// First-word fall-through {id, last} FIFO with occupancy/packet status and a registered status_id.
// Optional ID sequence checker is built when SHA256_ID_BUF_SEQ_CHECK_EN is defined.
module sha256_id_buf_v2 #(
   parameter int  ID_W  = 6,
   parameter int  DEPTH = 8,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 sync_rst,
   sha256_id_buf_v2_if.slave    bus,
   output logic [ID_W-1:0]      status_id,
   output logic [CNT_W-1:0]     occupancy,
   output logic                 full,
   output logic                 empty,
   output logic [CNT_W-1:0]     pkt_count,
   output logic                 seq_err
);

   logic [ID_W:0]      mem_r [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_r;
   logic [PTR_W-1:0]   rd_ptr_r;
   logic [CNT_W-1:0]   occ_r;
   logic [CNT_W-1:0]   pkt_r;
   logic [ID_W-1:0]    status_id_r;

   logic               active_s;
   logic               full_s;
   logic               empty_s;
   logic               push_s;
   logic               pop_s;
   logic [ID_W-1:0]    head_id_s;
   logic               head_last_s;
   logic [CNT_W-1:0]   occ_nxt_s;
   logic [CNT_W-1:0]   pkt_nxt_s;

   // Pointers wrap explicitly so DEPTH need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) begin
         return {PTR_W{1'b0}};
      end else begin
         return p + PTR_W'(1);
      end
   endfunction

   // Handshake qualification and next occupancy / packet count.
   always_comb begin
      active_s    = en & ~sync_rst;
      full_s      = (occ_r == CNT_W'(DEPTH));
      empty_s     = (occ_r == {CNT_W{1'b0}});
      head_id_s   = mem_r[rd_ptr_r][ID_W-1:0];
      head_last_s = mem_r[rd_ptr_r][ID_W];
      push_s      = bus.id_in_valid & active_s & ~full_s;
      pop_s       = bus.id_out_ready & active_s & ~empty_s;
      occ_nxt_s   = occ_r;
      pkt_nxt_s   = pkt_r;
      case ({push_s, pop_s})
         2'b10:   occ_nxt_s = occ_r + CNT_W'(1);
         2'b01:   occ_nxt_s = occ_r - CNT_W'(1);
         default: occ_nxt_s = occ_r;
      endcase
      case ({push_s & bus.id_in_last, pop_s & head_last_s})
         2'b10:   pkt_nxt_s = pkt_r + CNT_W'(1);
         2'b01:   pkt_nxt_s = pkt_r - CNT_W'(1);
         default: pkt_nxt_s = pkt_r;
      endcase
   end

   // Storage array; contents are not reset, only accepted beats are written.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= {bus.id_in_last, bus.id_in};
      end
   end

   // Pointers, counters and status_id.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r    <= {PTR_W{1'b0}};
         rd_ptr_r    <= {PTR_W{1'b0}};
         occ_r       <= {CNT_W{1'b0}};
         pkt_r       <= {CNT_W{1'b0}};
         status_id_r <= {ID_W{1'b0}};
      end else if (en) begin
         if (sync_rst) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            occ_r       <= {CNT_W{1'b0}};
            pkt_r       <= {CNT_W{1'b0}};
            status_id_r <= {ID_W{1'b0}};
         end else begin
            if (push_s) begin
               wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
               rd_ptr_r    <= ptr_inc(rd_ptr_r);
               status_id_r <= head_id_s;
            end
            occ_r <= occ_nxt_s;
            pkt_r <= pkt_nxt_s;
         end
      end
   end

`ifdef SHA256_ID_BUF_SEQ_CHECK_EN
   logic [ID_W-1:0] exp_id_r;
   logic            first_seen_r;
   logic            seq_err_r;

   // Expected-ID tracker: the first beat seeds it, each packet end advances it by one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_id_r     <= {ID_W{1'b0}};
         first_seen_r <= 1'b0;
         seq_err_r    <= 1'b0;
      end else if (en) begin
         if (sync_rst) begin
            exp_id_r     <= {ID_W{1'b0}};
            first_seen_r <= 1'b0;
            seq_err_r    <= 1'b0;
         end else if (push_s) begin
            first_seen_r <= 1'b1;
            if (first_seen_r && (bus.id_in != exp_id_r)) begin
               seq_err_r <= 1'b1;
            end
            if (bus.id_in_last) begin
               exp_id_r <= bus.id_in + ID_W'(1);
            end else if (!first_seen_r) begin
               exp_id_r <= bus.id_in;
            end
         end
      end
   end

   assign seq_err = seq_err_r;
`else
   assign seq_err = 1'b0;
`endif

   assign bus.id_in_ready  = active_s & ~full_s;
   assign bus.id_out_valid = active_s & ~empty_s;
   assign bus.id_out       = head_id_s;
   assign bus.id_out_last  = head_last_s;
   assign status_id        = status_id_r;
   assign occupancy        = occ_r;
   assign pkt_count        = pkt_r;
   assign full             = full_s;
   assign empty            = empty_s;

endmodule

// File: tb/tb_sha256_id_buf_v2.sv
// Scoreboard bench driving a DEPTH=8 and a DEPTH=5 instance with identical stimulus.
// Each instance has its own expected-beat queue and sequence-check model.
module tb_sha256_id_buf_v2;

   localparam bit SEQ_ON =
`ifdef SHA256_ID_BUF_SEQ_CHECK_EN
      1'b1;
`else
      1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst, en, sync_rst;
   logic [5:0] id_in;
   logic       id_in_last, id_in_valid, id_out_ready;

   always #5 clk = ~clk;

   sha256_id_buf_v2_if #(.ID_W(6)) bus8 ();
   sha256_id_buf_v2_if #(.ID_W(6)) bus5 ();

   assign bus8.id_in        = id_in;
   assign bus8.id_in_last   = id_in_last;
   assign bus8.id_in_valid  = id_in_valid;
   assign bus8.id_out_ready = id_out_ready;
   assign bus5.id_in        = id_in;
   assign bus5.id_in_last   = id_in_last;
   assign bus5.id_in_valid  = id_in_valid;
   assign bus5.id_out_ready = id_out_ready;

   logic [5:0] status8, status5;
   logic [3:0] occ8, pkt8;
   logic [2:0] occ5, pkt5;
   logic       full8, empty8, seq8, full5, empty5, seq5;

   sha256_id_buf_v2 #(.ID_W(6), .DEPTH(8)) dut8 (
      .clk(clk), .rst(rst), .en(en), .sync_rst(sync_rst), .bus(bus8),
      .status_id(status8), .occupancy(occ8), .full(full8), .empty(empty8),
      .pkt_count(pkt8), .seq_err(seq8)
   );

   sha256_id_buf_v2 #(.ID_W(6), .DEPTH(5)) dut5 (
      .clk(clk), .rst(rst), .en(en), .sync_rst(sync_rst), .bus(bus5),
      .status_id(status5), .occupancy(occ5), .full(full5), .empty(empty5),
      .pkt_count(pkt5), .seq_err(seq5)
   );

   logic [6:0] q8[$];
   logic [6:0] q5[$];
   logic [5:0] exp_st [2];
   logic [5:0] exp_id [2];
   bit         first  [2];
   bit         serr   [2];
   int         checks = 0;
   int         errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   function automatic int lasts(input logic [6:0] q[$]);
      int n = 0;
      foreach (q[i]) if (q[i][6]) n++;
      return n;
   endfunction

   task automatic seq_upd(input int k);
      if (SEQ_ON) begin
         if (first[k] && (id_in != exp_id[k])) serr[k] = 1'b1;
         if (id_in_last) exp_id[k] = id_in + 6'd1;
         else if (!first[k]) exp_id[k] = id_in;
         first[k] = 1'b1;
      end
   endtask

   task automatic model_clear();
      q8.delete();
      q5.delete();
      for (int k = 0; k < 2; k++) begin
         exp_st[k] = 6'd0;
         exp_id[k] = 6'd0;
         first[k]  = 1'b0;
         serr[k]   = 1'b0;
      end
   endtask

   task automatic post_chk();
      chk("occ8", 32'(occ8), 32'(q8.size()));
      chk("pkt8", 32'(pkt8), 32'(lasts(q8)));
      chk("empty8", 32'(empty8), 32'(q8.size() == 0));
      chk("full8", 32'(full8), 32'(q8.size() == 8));
      chk("status8", 32'(status8), 32'(exp_st[0]));
      chk("seq8", 32'(seq8), 32'(serr[0]));
      chk("occ5", 32'(occ5), 32'(q5.size()));
      chk("pkt5", 32'(pkt5), 32'(lasts(q5)));
      chk("empty5", 32'(empty5), 32'(q5.size() == 0));
      chk("full5", 32'(full5), 32'(q5.size() == 5));
      chk("status5", 32'(status5), 32'(exp_st[1]));
      chk("seq5", 32'(seq5), 32'(serr[1]));
   endtask

   // One clock: record handshakes at the falling edge, check state after the rising edge.
   task automatic cycle();
      logic [6:0] h;
      bit         clr;
      @(negedge clk);
      clr = en && sync_rst;
      if (!en || sync_rst) begin
         chk("in_ready_gated", 32'(bus8.id_in_ready), 32'd0);
         chk("out_valid_gated", 32'(bus8.id_out_valid), 32'd0);
      end
      if (bus8.id_in_valid && bus8.id_in_ready) begin
         q8.push_back({id_in_last, id_in});
         seq_upd(0);
      end
      if (bus5.id_in_valid && bus5.id_in_ready) begin
         q5.push_back({id_in_last, id_in});
         seq_upd(1);
      end
      if (bus8.id_out_valid && bus8.id_out_ready) begin
         chk("pop8_nonempty", 32'(q8.size() != 0), 32'd1);
         if (q8.size() != 0) begin
            h = q8.pop_front();
            chk("pop8_beat", 32'({bus8.id_out_last, bus8.id_out}), 32'(h));
            exp_st[0] = h[5:0];
         end
      end
      if (bus5.id_out_valid && bus5.id_out_ready) begin
         chk("pop5_nonempty", 32'(q5.size() != 0), 32'd1);
         if (q5.size() != 0) begin
            h = q5.pop_front();
            chk("pop5_beat", 32'({bus5.id_out_last, bus5.id_out}), 32'(h));
            exp_st[1] = h[5:0];
         end
      end
      @(posedge clk);
      #1;
      if (clr) model_clear();
      post_chk();
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; sync_rst = 1'b0;
      id_in = 6'd0; id_in_last = 1'b0; id_in_valid = 1'b0; id_out_ready = 1'b0;
      model_clear();
      @(posedge clk); @(posedge clk); #1;
      chk("rst_empty", 32'(empty8), 32'd1);
      chk("rst_full", 32'(full8), 32'd0);
      chk("rst_out_valid", 32'(bus8.id_out_valid), 32'd0);
      chk("rst_in_ready", 32'(bus8.id_in_ready), 32'd1);
      post_chk();
      rst = 1'b0;

      // Fill to full with ready low; the ninth beat must be refused.
      id_in_valid = 1'b1; id_in_last = 1'b1;
      for (int i = 0; i < 9; i++) begin
         id_in = 6'(i);
         cycle();
      end
      chk("fill_full", 32'(full8), 32'd1);
      chk("fill_occ", 32'(occ8), 32'd8);
      chk("fill_pkt", 32'(pkt8), 32'd8);
      chk("fill_in_ready", 32'(bus8.id_in_ready), 32'd0);
      chk("fill_head", 32'(bus8.id_out), 32'd0);

      // Drain everything; the smaller instance hits empty early.
      id_in_valid = 1'b0; id_out_ready = 1'b1;
      for (int i = 0; i < 9; i++) cycle();
      chk("drain_empty", 32'(empty8), 32'd1);
      chk("drain_status", 32'(status8), 32'd7);

      // Level 3 then continuous push+pop, wrapping both pointer sets.
      id_out_ready = 1'b0; id_in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         id_in = 6'(8 + i);
         cycle();
      end
      id_out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         id_in = 6'(11 + i);
         cycle();
         chk("lvl3_occ8", 32'(occ8), 32'd3);
         chk("lvl3_occ5", 32'(occ5), 32'd3);
      end
      id_in_valid = 1'b0;
      for (int i = 0; i < 3; i++) cycle();

      // Synchronous clear with both handshakes requested.
      id_out_ready = 1'b0; id_in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         id_in = 6'(31 + i);
         cycle();
      end
      sync_rst = 1'b1; id_out_ready = 1'b1; id_in = 6'd35;
      cycle();
      sync_rst = 1'b0; id_in_valid = 1'b0; id_out_ready = 1'b0;
      chk("srst_occ", 32'(occ8), 32'd0);
      chk("srst_pkt", 32'(pkt8), 32'd0);
      chk("srst_status", 32'(status8), 32'd0);

      // Asynchronous reset in the middle of popping.
      id_in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         id_in = 6'(40 + i);
         cycle();
      end
      id_in_valid = 1'b0; id_out_ready = 1'b1;
      cycle();
      #1 rst = 1'b1;
      #1;
      chk("arst_occ", 32'(occ8), 32'd0);
      chk("arst_pkt", 32'(pkt8), 32'd0);
      chk("arst_status", 32'(status8), 32'd0);
      chk("arst_out_valid", 32'(bus8.id_out_valid), 32'd0);
      #1 rst = 1'b0;
      model_clear();
      id_out_ready = 1'b0;
      cycle();

      // Enable low freezes everything despite valid/ready.
      id_in_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         id_in = 6'(50 + i);
         cycle();
      end
      en = 1'b0; id_out_ready = 1'b1; id_in = 6'd52;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("en0_occ", 32'(occ8), 32'd2);
      end
      en = 1'b1; id_in_valid = 1'b0;
      for (int i = 0; i < 2; i++) cycle();
      id_out_ready = 1'b0;

      // ID sequence check: 5, 5(last), 6(last), 9.
      sync_rst = 1'b1;
      cycle();
      sync_rst = 1'b0; id_in_valid = 1'b1;
      id_in = 6'd5; id_in_last = 1'b0; cycle();
      id_in = 6'd5; id_in_last = 1'b1; cycle();
      id_in = 6'd6; id_in_last = 1'b1; cycle();
      chk("seq_before_9", 32'(seq8), 32'd0);
      id_in = 6'd9; id_in_last = 1'b0; cycle();
      chk("seq_after_9", 32'(seq8), 32'(SEQ_ON));
      id_in_valid = 1'b0;
      for (int i = 0; i < 3; i++) cycle();
      chk("seq_sticky", 32'(seq8), 32'(SEQ_ON));
      sync_rst = 1'b1;
      cycle();
      sync_rst = 1'b0;
      chk("seq_cleared", 32'(seq8), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
